pipe_stage_buffer: RTL

Parametrised elastic pipeline-stage register for the PDA core, carrying one stage's control-signal bundle and datapath bundle between adjacent stages (deco→exe, exe→mem, mem→wb). It adds a valid/ready handshake, an optional two-entry skid buffer for full throughput with registered backpressure, synchronous flush with NOP-bubble insertion, and occupancy and starvation counters. One instance replaces each hand-built stage register.

---
 rtl/pipe_stage_buffer.sv | 118 +++++++++++
 1 files changed

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline-stage register: valid/ready handshake, optional two-entry skid,
// synchronous flush with NOP bubbles, and a saturating starvation counter.
module pipe_stage_buffer #(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 128,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_count
);

  // state    | meaning
  // ST_EMPTY | nothing held, outputs show a bubble
  // ST_ONE   | main register M valid and presented
  // ST_FULL  | M presented, skid register S holds the next entry
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic              ready_q, ready_d;
  logic              in_xfer, out_xfer;

  // ready_q is low through reset in both modes, so in_ready stays 0 until the first edge
  assign in_ready  = (SKID == 0) ? (ready_q & (~out_valid | out_ready)) : ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_ctrl  = out_valid ? m_ctrl_q : '0;
  assign out_data  = m_data_q;
  assign occupancy = state_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign ready_d   = (SKID == 0) ? 1'b1 : (state_d != ST_FULL);

  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d  = ST_ONE;
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end else if (in_xfer) begin
            state_d  = ST_FULL;
            s_ctrl_d = in_ctrl;
            s_data_d = in_data;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            state_d  = ST_ONE;
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
      ready_q  <= ready_d;
    end
  end

  // starvation counter survives flush; only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (!out_valid && out_ready && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule
